// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int unsigned N            = 16;
    localparam int unsigned SEL_W        = $clog2(N);
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated find-first: lowest eligible requester at or after start, wrapping modulo N.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] winner_c,
    output logic             any_c
);

    localparam int unsigned POS_W = SEL_W + 1;

    logic [N-1:0]     eligible;
    logic [2*N-1:0]   dbl;
    logic [2*N-1:0]   dbl_from_start;
    logic [POS_W-1:0] pos;
    logic [SEL_W-1:0] offset;

    // Doubling the vector turns the wrap-around search into a plain priority encode.
    always_comb begin
        eligible       = req & ~mask;
        dbl            = {eligible, eligible};
        dbl_from_start = dbl & ({(2*N){1'b1}} << start);
        pos            = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl_from_start[i]) begin
                pos = POS_W'(i);
            end
        end
        offset   = SEL_W'(pos - {1'b0, start});
        winner_c = start + offset;
        any_c    = |eligible;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 bit mux, with bounded hold time
// and a registered copy of the selected data bit.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     data_in,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             data_out,
    output logic             timeout
);

    localparam int unsigned      HOLD_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic              data_out_q, data_out_d;
    logic              timeout_q, timeout_d;

    logic [SEL_W-1:0]  pick_start_c;
    logic [N-1:0]      pick_mask_c;
    logic [SEL_W-1:0]  pick_winner_c;
    logic              pick_any_c;
    logic              take_c;

    // While granted, the search starts after the holder and never returns the holder itself.
    always_comb begin
        pick_start_c = ptr_q;
        pick_mask_c  = '0;
        if (state_q == GRANT) begin
            pick_start_c = sel_q + 1'b1;
            pick_mask_c  = onehot(sel_q);
        end
    end

    rr_pick u_pick (
        .req      (req),
        .mask     (pick_mask_c),
        .start    (pick_start_c),
        .winner_c (pick_winner_c),
        .any_c    (pick_any_c)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        timeout_d   = 1'b0;
        take_c      = 1'b0;
        data_out_d  = sel_valid_q ? data_in[sel_q] : 1'b0;

        unique case (state_q)
            IDLE: begin
                take_c = pick_any_c;
            end
            GRANT: begin
                hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
                if (!req[sel_q]) begin
                    ptr_d = pick_start_c;
                    if (pick_any_c) begin
                        take_c = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        sel_valid_d = 1'b0;
                        hold_cnt_d  = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
                    // Revoke only under contention; a lone holder just restarts its count.
                    hold_cnt_d = '0;
                    if (pick_any_c) begin
                        take_c    = 1'b1;
                        ptr_d     = pick_start_c;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_c) begin
            state_d     = GRANT;
            gnt_d       = onehot(pick_winner_c);
            sel_d       = pick_winner_c;
            sel_valid_d = 1'b1;
            hold_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            data_out_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            data_out_q  <= data_out_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign data_out  = data_out_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter sharing one 16:1 bit-multiplexer between 16 requesters.
- Drives the 4-bit select and a one-hot grant, and captures the granted requester's data bit into a registered output.
- Bounded hold time prevents starvation.
- Sits in front of the existing 16:1 mux datapath; it is the mux's only select source.

Parameters:
- N, 16, number of requesters (power of two).
- SEL_W, 4, select width, equal to log2(N).
- MAX_HOLD, 8, maximum consecutive cycles one grant may persist; 0 = unlimited.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level; held high while the requester uses the mux.
- data_in  input  N  per-requester data bit (mux data inputs).
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- sel  output  SEL_W  mux select, registered; index of the granted requester.
- sel_valid  output  1  high while a grant is active.
- data_out  output  1  registered data_in[sel], valid one cycle after sel.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the user): gnt=0, sel=0, sel_valid=0, data_out=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
- ptr (SEL_W bits) is the highest-priority index; the search order is ptr, ptr+1, … wrapping modulo N.
- FSM states:
  - IDLE:
    - req==0: stay IDLE.
    - Otherwise, at the next edge: grant the first set bit at or after ptr; load sel and one-hot gnt, set sel_valid, clear hold_cnt, go to GRANT.
    - Latency from req rising to gnt is 1 cycle.
  - GRANT: each cycle, hold_cnt increments (saturating), and one of three cases applies.
    - Release (req[sel]==0):
      - ptr <= sel+1 (wraps 15->0).
      - If any other req is set, grant the next winner (search from sel+1) on the same edge. There is no idle bubble, and hold_cnt clears.
      - If no other req is set, go to IDLE with gnt=0 and sel_valid=0. sel keeps its last value.
    - Timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[sel] still 1):
      - If another requester is pending: mask the holder, grant the next winner from sel+1, set ptr <= sel+1, pulse timeout for 1 cycle.
      - If no other requester is pending: the holder keeps the grant, hold_cnt clears, and there is no timeout pulse.
    - Otherwise: hold the current grant.
- A grant therefore lasts at most MAX_HOLD cycles while contention exists.
- Simultaneous release plus new request from the same index: the release is honoured, and the index is re-eligible only through normal round-robin order from sel+1.
- data_out: at every edge, data_out <= sel_valid ? data_in[sel] : 0, using the registered sel. This gives 1-cycle latency from the sel change.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[sel]==1 whenever sel_valid==1.
  - sel_valid == |gnt.
- Reset mid-grant: all outputs clear immediately (asynchronously); on release from reset, arbitration restarts from ptr=0.
- hold_cnt width: $clog2(MAX_HOLD)+1; unused when MAX_HOLD==0.

Decomposition:
- Shared package holds:
  - N and SEL_W constants.
  - state enum {IDLE, GRANT}.
  - MAX_HOLD default.
- Sub-module rr_pick: combinational rotated find-first. Inputs are req, mask and start index; outputs are the winner index and an any flag. It is implemented as double-width concatenation, priority encode, subtract start.
- The top contains the FSM, ptr, hold_cnt and the output registers.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> gnt=0, sel_valid=0, data_out=0 throughout.
- req=16'h0021 from idle, ptr=0 -> next cycle gnt=16'h0001, sel=0. Drop req[0] -> next edge gnt=16'h0020, sel=5 with no bubble. Drop req[5] -> IDLE, ptr=6.
- Wrap: ptr=14 (reach via prior grant of 13), req=16'h0005 -> grant order 0 then 2; sel never jumps to 1 or 3.
- Timeout with MAX_HOLD=8: req=16'h0003 held constant -> requester 0 granted for 8 cycles, then 1-cycle timeout pulse and sel=1 for 8 cycles, alternating. Sole requester 16'h0001 held for 20 cycles -> never times out.
- Data path: grant to 7, data_in[7] toggling 1,0,1 -> data_out follows one cycle later. Other data_in bits toggling have no effect.
- Assert rst_n=0 mid-grant between clock edges -> gnt, sel_valid and data_out go 0 before the next edge. After release, req=16'h8000 -> sel=15 granted one cycle later.
